tw_cpu_core: RTL and testbench
==============================

Name: tw_cpu_core

Overview:
- Parametrised successor of the TW4 core: same 16-opcode ISA, user/privileged register banks, A-only SWAP and SWI.
- Generalises data and address width.
- Adds a stalling instruction-fetch handshake, a saved return PC (EPC), a RETI instruction and a hardware interrupt entry.
- Sits between instruction ROM/bus and the board I/O as the top-level execution unit.

Parameters:
- DATA_W, 4: width of the A, B, in, out and imm fields.
- ADDR_W, 4: width of the PC. Must satisfy ADDR_W <= DATA_W; jump targets are imm[ADDR_W-1:0].
- SWI_VEC, 0: PC loaded on SWI.
- IRQ_VEC, 8 (truncated to ADDR_W): PC loaded on hardware interrupt entry.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- fetch_addr  out  ADDR_W+1  {priv, pc} of the instruction being fetched
- instr  in  4+DATA_W  {opcode[3:0], imm[DATA_W-1:0]}
- instr_valid  in  1  instr is valid for fetch_addr this cycle
- in_port  in  DATA_W  input port
- out_port  out  DATA_W  registered output port
- irq  in  1  level-sensitive interrupt request
- irq_ack  out  1  one-cycle pulse on interrupt entry

Behaviour:
- Reset (asynchronous, active-high; legal mid-stall or mid-instruction). Every register clears immediately and asynchronously, with no partial commit:
  - both banks: A=0, B=0, C=0
  - pc=0, priv=0, epc=0
  - out_port=0, irq_ack=0
- Execution:
  - One instruction per cycle in which instr_valid=1.
  - When instr_valid=0 (stall), no architectural state changes, fetch_addr is held and irq is not sampled.
- Active bank = priv ? priv bank : user bank. Only the active bank is written, except by SWAP.
- Default next PC: pc+1, wrapping modulo 2^ADDR_W with no carry effect.
- Opcodes, in order 0..15:
  - ADD_A_IMM: {C,A} = A+imm, computed DATA_W+1 wide.
  - MOV_A_B
  - IN_A
  - MOV_A_IMM
  - MOV_B_A
  - ADD_B_IMM: {C,B} = B+imm.
  - IN_B
  - MOV_B_IMM
  - NOP0
  - OUT_B
  - RETI (replaces NOP1):
    - Privileged: pc=epc, priv=0.
    - User: NOP.
  - OUT_IMM
  - SWAP:
    - Privileged: exchange user.A and priv.A.
    - User: NOP.
  - SWI:
    - User: epc=pc+1, priv=1, pc=SWI_VEC.
    - Privileged: NOP.
  - JNC: pc=imm[ADDR_W-1:0] if C==0, else pc+1.
  - JMP: pc=imm[ADDR_W-1:0].
- C is written only by the ADD instructions; every other instruction preserves it.
- out_port is registered and changes only on OUT_B or OUT_IMM.
- Interrupt entry: taken when instr_valid=1, irq=1 and priv=0.
  - The fetched instruction is discarded, not executed.
  - epc=pc (the discarded instruction is re-executed after RETI), priv=1, pc=IRQ_VEC.
  - irq_ack=1 in the following cycle only.
- Interrupt masking and priority:
  - irq is ignored while priv=1; a pending irq is taken at the first valid fetch after RETI.
  - irq has priority over an SWI in the same cycle; that SWI re-executes after RETI.
  - Nesting is impossible: a single EPC suffices.
- FSM (state is the priv bit plus the stall condition):
  - USER -> PRIV on SWI or irq.
  - PRIV -> USER on RETI.
  - Each state self-loops on stall.

Optional Feature:
- Macro TW_SWAP_B_EN.
- Defined: privileged SWAP exchanges both user.A<->priv.A and user.B<->priv.B in one cycle. C is untouched.
- Undefined: SWAP exchanges A only. B banks are untouched.

Decomposition:
- Package tw_pkg holds:
  - opcode_t enum (4-bit, values above)
  - OPCODE_W=4
  - mode constants MODE_USER=0, MODE_PRIV=1
- Bank registers are declared in the core using DATA_W-sized fields, since the package holds no parametrised structs.
- One sub-module: tw_exec. It is purely combinational and maps (opcode, imm, active bank, in_port, pc, priv, epc, C) to next bank values, next pc/priv/epc, out write-enable/value and a do_swap flag.
- The tw_cpu_core top holds all flops, the stall gating and the interrupt logic.

Test Plan:
- Reset mid-run, then release with instr_valid=1 and MOV_A_IMM 5 at pc0 -> fetch_addr={0,0}; next cycle user.A=5, pc=1, out_port=0.
- ADD_A_IMM 9 with A=8 (DATA_W=4) -> A=1, C=1; a following JNC 3 falls through to pc+1. With C=0 the same JNC loads pc=3.
- User SWI at pc=6 -> priv=1, pc=0, epc=7.
  - Privileged SWAP with user.A=3, priv.A=0xA -> user.A=0xA, priv.A=3.
  - RETI -> priv=0, pc=7.
- irq=1 while user at pc=4 holding OUT_IMM 0xF -> out_port unchanged, epc=4, pc=8, priv=1, irq_ack pulse next cycle. irq held high during the privileged handler -> no second entry.
- instr_valid=0 for 3 cycles with irq=1 -> fetch_addr, registers and out_port frozen; no irq_ack.
- TW_SWAP_B_EN defined: privileged SWAP with user.B=2, priv.B=7 -> user.B=7, priv.B=2. With the macro undefined, both B values are unchanged.

Source files
------------

// File: rtl/tw_pkg.sv
// Shared opcode encoding and privilege mode values for the TW core.
package tw_pkg;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    ADD_A_IMM = 4'd0,
    MOV_A_B   = 4'd1,
    IN_A      = 4'd2,
    MOV_A_IMM = 4'd3,
    MOV_B_A   = 4'd4,
    ADD_B_IMM = 4'd5,
    IN_B      = 4'd6,
    MOV_B_IMM = 4'd7,
    NOP0      = 4'd8,
    OUT_B     = 4'd9,
    RETI      = 4'd10,
    OUT_IMM   = 4'd11,
    SWAP      = 4'd12,
    SWI       = 4'd13,
    JNC       = 4'd14,
    JMP       = 4'd15
  } opcode_t;

  typedef enum logic {
    MODE_USER = 1'b0,
    MODE_PRIV = 1'b1
  } mode_t;

endpackage

// File: rtl/tw_exec.sv
// Combinational instruction decode/execute for the TW core: maps one fetched
// instruction and the active bank to its architectural next-state values.
module tw_exec
  import tw_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned SWI_VEC = 0
) (
  input  opcode_t             opcode,
  input  logic [DATA_W-1:0]   imm,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                c,
  input  logic [DATA_W-1:0]   in_port,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [ADDR_W-1:0]   epc,
  input  logic                priv,
  output logic [DATA_W-1:0]   next_a,
  output logic [DATA_W-1:0]   next_b,
  output logic                next_c,
  output logic [ADDR_W-1:0]   next_pc,
  output logic [ADDR_W-1:0]   next_epc,
  output logic                next_priv,
  output logic                out_we,
  output logic [DATA_W-1:0]   out_val,
  output logic                do_swap
);

  logic [DATA_W:0]   sum_a;
  logic [DATA_W:0]   sum_b;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;

  assign sum_a  = {1'b0, a} + {1'b0, imm};
  assign sum_b  = {1'b0, b} + {1'b0, imm};
  assign pc_inc = pc + ADDR_W'(1);
  assign target = imm[ADDR_W-1:0];

  always_comb begin
    next_a    = a;
    next_b    = b;
    next_c    = c;
    next_pc   = pc_inc;
    next_epc  = epc;
    next_priv = priv;
    out_we    = 1'b0;
    out_val   = '0;
    do_swap   = 1'b0;
    case (opcode)
      ADD_A_IMM: {next_c, next_a} = sum_a;
      MOV_A_B:   next_a = b;
      IN_A:      next_a = in_port;
      MOV_A_IMM: next_a = imm;
      MOV_B_A:   next_b = a;
      ADD_B_IMM: {next_c, next_b} = sum_b;
      IN_B:      next_b = in_port;
      MOV_B_IMM: next_b = imm;
      NOP0:      ;
      OUT_B: begin
        out_we  = 1'b1;
        out_val = b;
      end
      RETI: if (priv) begin
        next_pc   = epc;
        next_priv = 1'b0;
      end
      OUT_IMM: begin
        out_we  = 1'b1;
        out_val = imm;
      end
      SWAP:      do_swap = priv;
      SWI: if (!priv) begin
        next_epc  = pc_inc;
        next_priv = 1'b1;
        next_pc   = ADDR_W'(SWI_VEC);
      end
      JNC:       if (!c) next_pc = target;
      JMP:       next_pc = target;
      default:   ;
    endcase
  end

endmodule

// File: rtl/tw_cpu_core.sv
// TW execution core: banked registers, stalling fetch, SWI/RETI and irq entry.
// Define TW_SWAP_B_EN to make privileged SWAP also exchange the B banks.
module tw_cpu_core
  import tw_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned SWI_VEC = 0,
  parameter int unsigned IRQ_VEC = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [ADDR_W:0]            fetch_addr,
  input  logic [OPCODE_W+DATA_W-1:0] instr,
  input  logic                       instr_valid,
  input  logic [DATA_W-1:0]          in_port,
  output logic [DATA_W-1:0]          out_port,
  input  logic                       irq,
  output logic                       irq_ack
);

  // Index 0 is the user bank, index 1 the privileged bank.
  logic [DATA_W-1:0] bank_a [2];
  logic [DATA_W-1:0] bank_b [2];
  logic              bank_c [2];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] epc;
  mode_t             mode;

  logic              priv;
  logic              irq_take;
  opcode_t           opcode;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;
  logic              next_c;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] next_epc;
  logic              next_priv;
  logic              out_we;
  logic [DATA_W-1:0] out_val;
  logic              do_swap;

  assign priv       = (mode == MODE_PRIV);
  assign opcode     = opcode_t'(instr[OPCODE_W+DATA_W-1:DATA_W]);
  assign imm        = instr[DATA_W-1:0];
  assign fetch_addr = {priv, pc};
  // irq is only sampled on a valid fetch in user mode; it preempts that fetch.
  assign irq_take   = instr_valid && irq && !priv;

  tw_exec #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SWI_VEC (SWI_VEC)
  ) u_exec (
    .opcode    (opcode),
    .imm       (imm),
    .a         (bank_a[priv]),
    .b         (bank_b[priv]),
    .c         (bank_c[priv]),
    .in_port   (in_port),
    .pc        (pc),
    .epc       (epc),
    .priv      (priv),
    .next_a    (next_a),
    .next_b    (next_b),
    .next_c    (next_c),
    .next_pc   (next_pc),
    .next_epc  (next_epc),
    .next_priv (next_priv),
    .out_we    (out_we),
    .out_val   (out_val),
    .do_swap   (do_swap)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_a[0] <= '0;
      bank_a[1] <= '0;
      bank_b[0] <= '0;
      bank_b[1] <= '0;
      bank_c[0] <= 1'b0;
      bank_c[1] <= 1'b0;
      pc        <= '0;
      epc       <= '0;
      mode      <= MODE_USER;
      out_port  <= '0;
      irq_ack   <= 1'b0;
    end else begin
      irq_ack <= irq_take;
      if (irq_take) begin
        epc  <= pc;
        mode <= MODE_PRIV;
        pc   <= ADDR_W'(IRQ_VEC);
      end else if (instr_valid) begin
        pc   <= next_pc;
        epc  <= next_epc;
        mode <= next_priv ? MODE_PRIV : MODE_USER;
        if (do_swap) begin
          bank_a[0] <= bank_a[1];
          bank_a[1] <= bank_a[0];
`ifdef TW_SWAP_B_EN
          bank_b[0] <= bank_b[1];
          bank_b[1] <= bank_b[0];
`endif
        end else begin
          bank_a[priv] <= next_a;
          bank_b[priv] <= next_b;
        end
        bank_c[priv] <= next_c;
        if (out_we) out_port <= out_val;
      end
    end
  end

endmodule

// File: tb/tb_tw_cpu_core.sv
// Self-checking bench for tw_cpu_core: directed ISA scenarios plus a random
// instruction stream compared cycle by cycle against a behavioural model.
module tb_tw_cpu_core;
  import tw_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int SWI_V = 0;
  localparam int IRQ_V = 8;
  localparam int DMASK = (1 << DW) - 1;
  localparam int AMASK = (1 << AW) - 1;
`ifdef TW_SWAP_B_EN
  localparam bit SWB = 1'b1;
`else
  localparam bit SWB = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [AW:0]       fetch_addr;
  logic [4+DW-1:0]   instr;
  logic              instr_valid;
  logic [DW-1:0]     in_port;
  logic [DW-1:0]     out_port;
  logic              irq;
  logic              irq_ack;

  always #5 clock = ~clock;

  tw_cpu_core #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .SWI_VEC (SWI_V),
    .IRQ_VEC (IRQ_V)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_addr  (fetch_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .in_port     (in_port),
    .out_port    (out_port),
    .irq         (irq),
    .irq_ack     (irq_ack)
  );

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;

  // Architectural model: index 0 user bank, index 1 privileged bank.
  int m_a [2];
  int m_b [2];
  int m_c [2];
  int m_pc, m_priv, m_epc, m_out, m_ack;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_a[i] = 0; m_b[i] = 0; m_c[i] = 0;
    end
    m_pc = 0; m_priv = 0; m_epc = 0; m_out = 0; m_ack = 0;
  endfunction

  function automatic void model_step(input int op, input int imm, input int vld,
                                     input int irq_v, input int inp);
    int k, npc, s, t;
    m_ack = (vld != 0 && irq_v != 0 && m_priv == 0) ? 1 : 0;
    if (vld == 0) return;
    if (m_ack != 0) begin
      m_epc  = m_pc;
      m_priv = 1;
      m_pc   = IRQ_V & AMASK;
      return;
    end
    k   = m_priv;
    npc = (m_pc + 1) & AMASK;
    case (op)
      0:  begin s = m_a[k] + imm; m_a[k] = s & DMASK; m_c[k] = s >> DW; end
      1:  m_a[k] = m_b[k];
      2:  m_a[k] = inp;
      3:  m_a[k] = imm;
      4:  m_b[k] = m_a[k];
      5:  begin s = m_b[k] + imm; m_b[k] = s & DMASK; m_c[k] = s >> DW; end
      6:  m_b[k] = inp;
      7:  m_b[k] = imm;
      9:  m_out = m_b[k];
      10: if (m_priv != 0) begin npc = m_epc; m_priv = 0; end
      11: m_out = imm;
      12: if (m_priv != 0) begin
            t = m_a[0]; m_a[0] = m_a[1]; m_a[1] = t;
            if (SWB) begin t = m_b[0]; m_b[0] = m_b[1]; m_b[1] = t; end
          end
      13: if (m_priv == 0) begin m_epc = npc; m_priv = 1; npc = SWI_V & AMASK; end
      14: if (m_c[k] == 0) npc = imm & AMASK;
      15: npc = imm & AMASK;
      default: ;
    endcase
    m_pc = npc;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic cyc(input int op, input int imm, input int vld = 1, input int irq_v = 0);
    int inp;
    inp         = $urandom_range(0, DMASK);
    instr       = (4+DW)'((op << DW) | (imm & DMASK));
    instr_valid = (vld != 0);
    irq         = (irq_v != 0);
    in_port     = DW'(inp);
    @(posedge clock);
    #1;
    if (reset) model_reset();
    else model_step(op, imm & DMASK, vld, irq_v, inp);
  endtask

  always @(negedge clock) begin
    if (run) begin
      chk("fetch_addr", int'(fetch_addr), (m_priv << AW) | m_pc);
      chk("out_port", int'(out_port), m_out);
      chk("irq_ack", int'(irq_ack), m_ack);
    end
  end

  initial begin
    reset = 1'b1; instr = '0; instr_valid = 1'b0; in_port = '0; irq = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    run   = 1'b1;
    reset = 1'b0;
    cyc(MOV_A_IMM, 7); cyc(ADD_B_IMM, 3); cyc(OUT_B, 0); cyc(SWI, 0);
    // Asynchronous reset in the middle of the run.
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_fetch", int'(fetch_addr), 0);
    chk("rst_out", int'(out_port), 0);
    cyc(OUT_IMM, 9);
    reset = 1'b0;
    chk("rel_fetch", int'(fetch_addr), 0);
    cyc(MOV_A_IMM, 5);
    chk("mov_a", m_a[0], 5);
    chk("mov_pc", int'(fetch_addr), 1);
    chk("mov_out", int'(out_port), 0);
    cyc(MOV_B_A, 0); cyc(OUT_B, 0);
    chk("out_b5", int'(out_port), 5);
    // Carry out of ADD and its effect on JNC.
    cyc(MOV_A_IMM, 8); cyc(ADD_A_IMM, 9);
    chk("add_a", m_a[0], 1);
    chk("add_c", m_c[0], 1);
    cyc(JNC, 3);
    chk("jnc_fall", int'(fetch_addr), 6);
    cyc(ADD_A_IMM, 0); cyc(JNC, 3);
    chk("jnc_take", int'(fetch_addr), 3);
    // SWI, privileged SWAP, RETI.
    cyc(MOV_A_IMM, 3); cyc(MOV_B_IMM, 2); cyc(JMP, 6); cyc(SWI, 0);
    chk("swi_fetch", int'(fetch_addr), 'h10);
    chk("swi_epc", m_epc, 7);
    cyc(MOV_A_IMM, 10); cyc(MOV_B_IMM, 7); cyc(SWAP, 0);
    chk("swap_ua", m_a[0], 10);
    chk("swap_pa", m_a[1], 3);
    cyc(OUT_B, 0);
    chk("swap_pb", int'(out_port), SWB ? 2 : 7);
    cyc(RETI, 0);
    chk("reti_fetch", int'(fetch_addr), 7);
    cyc(OUT_B, 0);
    chk("swap_ub", int'(out_port), SWB ? 7 : 2);
    cyc(MOV_B_A, 0); cyc(OUT_B, 0);
    chk("swap_ua_out", int'(out_port), 10);
    // Hardware interrupt discards OUT_IMM at pc 4.
    cyc(JMP, 4);
    cyc(OUT_IMM, 15, 1, 1);
    chk("irq_out", int'(out_port), 10);
    chk("irq_fetch", int'(fetch_addr), 'h18);
    chk("irq_ack1", int'(irq_ack), 1);
    chk("irq_epc", m_epc, 4);
    cyc(NOP0, 0, 1, 1);
    chk("irq_masked", int'(fetch_addr), 'h19);
    chk("irq_ack0", int'(irq_ack), 0);
    cyc(RETI, 0);
    chk("irq_reti", int'(fetch_addr), 4);
    // Stall with irq high: nothing moves.
    for (int i = 0; i < 3; i++) begin
      cyc(OUT_IMM, 15, 0, 1);
      chk("stall_fetch", int'(fetch_addr), 4);
      chk("stall_ack", int'(irq_ack), 0);
      chk("stall_out", int'(out_port), 10);
    end
    cyc(OUT_IMM, 15);
    chk("post_stall_out", int'(out_port), 15);
    // Random instruction stream.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
      end
      cyc($urandom_range(0, 15), $urandom_range(0, DMASK),
          ($urandom_range(0, 4) != 0) ? 1 : 0,
          ($urandom_range(0, 9) == 0) ? 1 : 0);
      reset = 1'b0;
    end
    @(negedge clock);
    #1;
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
